// File: rtl/grid_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : grid_access_ctrl
// Brief    : Single-port arbiter for the 28x28 drawing buffer (clear/draw/scan)
// Revision : 1.0
// ============================================================================
module grid_access_ctrl #(
   parameter int GRID_SIZE = 28,
   parameter int CELLS     = 784,
   parameter int ADDR_W    = 10
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              clear_req,
   output logic              clear_done,
   input  logic              draw_req,
   input  logic [4:0]        draw_x,
   input  logic [4:0]        draw_y,
   output logic              draw_gnt,
   input  logic              scan_start,
   output logic              scan_valid,
   input  logic              scan_ready,
   output logic              scan_data,
   output logic [ADDR_W-1:0] scan_index,
   output logic              scan_last,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_wdata,
   input  logic              mem_rdata,
   output logic              busy
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_CLEAR     = 3'd1;
   localparam logic [2:0] S_SCAN_ADDR = 3'd2;
   localparam logic [2:0] S_SCAN_CAP  = 3'd3;
   localparam logic [2:0] S_SCAN_OUT  = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(CELLS - 1);
   localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] IDX_ZERO  = '0;
   localparam logic [4:0]        MAX_COORD = 5'(GRID_SIZE - 1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              scan_valid_q, scan_valid_d;
   logic              scan_data_q, scan_data_d;
   logic [ADDR_W-1:0] scan_index_q, scan_index_d;
   logic              scan_last_q, scan_last_d;
   logic              clear_done_q, clear_done_d;

   logic [ADDR_W-1:0] draw_addr;
   logic [ADDR_W-1:0] draw_y_ext;
   logic              draw_in_range;
   logic              draw_take;

   // y*28 as a shift-add so no multiplier is inferred
   assign draw_y_ext    = ADDR_W'(draw_y);
   assign draw_addr     = (draw_y_ext << 4) + (draw_y_ext << 3) + (draw_y_ext << 2)
                        + ADDR_W'(draw_x);
   assign draw_in_range = (draw_x <= MAX_COORD) && (draw_y <= MAX_COORD);
   assign draw_take     = (state_q == S_IDLE) && draw_req && !clear_req && !scan_start;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= IDX_ZERO;
         scan_valid_q <= 1'b0;
         scan_data_q  <= 1'b0;
         scan_index_q <= IDX_ZERO;
         scan_last_q  <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         scan_valid_q <= scan_valid_d;
         scan_data_q  <= scan_data_d;
         scan_index_q <= scan_index_d;
         scan_last_q  <= scan_last_d;
         clear_done_q <= clear_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      scan_valid_d = scan_valid_q;
      scan_data_d  = scan_data_q;
      scan_index_d = scan_index_q;
      scan_last_d  = scan_last_q;
      clear_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (clear_req) begin
               state_d = S_CLEAR;
               idx_d   = IDX_ZERO;
            end else if (scan_start) begin
               state_d = S_SCAN_ADDR;
               idx_d   = IDX_ZERO;
            end
         end
         S_CLEAR: begin
            if (clear_req) begin
               idx_d = IDX_ZERO;
            end else if (idx_q == LAST_IDX) begin
               state_d      = S_IDLE;
               idx_d        = IDX_ZERO;
               clear_done_d = 1'b1;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         S_SCAN_ADDR, S_SCAN_CAP, S_SCAN_OUT: begin
            if (clear_req) begin
               state_d      = S_CLEAR;
               idx_d        = IDX_ZERO;
               scan_valid_d = 1'b0;
            end else if (state_q == S_SCAN_ADDR) begin
               state_d = S_SCAN_CAP;
            end else if (state_q == S_SCAN_CAP) begin
               scan_data_d  = mem_rdata;
               scan_index_d = idx_q;
               scan_last_d  = (idx_q == LAST_IDX);
               scan_valid_d = 1'b1;
               state_d      = S_SCAN_OUT;
            end else if (scan_valid_q && scan_ready) begin
               scan_valid_d = 1'b0;
               if (scan_last_q) begin
                  state_d = S_IDLE;
                  idx_d   = IDX_ZERO;
               end else begin
                  state_d = S_SCAN_ADDR;
                  idx_d   = idx_q + IDX_ONE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = IDX_ZERO;
         end
      endcase
   end

   always_comb begin
      mem_addr  = idx_q;
      mem_we    = 1'b0;
      mem_wdata = 1'b0;
      draw_gnt  = 1'b0;
      case (state_q)
         S_IDLE: begin
            mem_addr = draw_addr;
            if (draw_take) begin
               draw_gnt  = 1'b1;
               mem_we    = draw_in_range;
               mem_wdata = 1'b1;
            end
         end
         S_CLEAR: begin
            mem_we = 1'b1;
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
      // Reset must silence the memory port in the same cycle it is raised
      if (reset) begin
         mem_we   = 1'b0;
         draw_gnt = 1'b0;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign scan_valid = scan_valid_q;
   assign scan_data  = scan_data_q;
   assign scan_index = scan_index_q;
   assign scan_last  = scan_last_q;
   assign clear_done = clear_done_q;

endmodule
`default_nettype wire
